// File: rtl/edge_event_scheduler_pkg.sv
// Shared constants for the edge event scheduler: default channel count,
// index width and the presenter state encoding.
package edge_event_scheduler_pkg;

    localparam int NCH_DEF = 4;
    localparam int CHW_DEF = $clog2(NCH_DEF);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/edge_event_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel strictly after
// last_grant, wrapping through NCH-1 back to 0 (last_grant itself is last).
module rr_arbiter
    import edge_event_scheduler_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] last_grant,
    output logic           grant_valid,
    output logic [CHW-1:0] grant_idx
);

    logic [CHW-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest requester wins;
    // NCH is a power of two, so index arithmetic wraps naturally.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_cand      = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_cand = last_grant + CHW'(k);
            if (req[w_cand]) begin
                grant_valid = 1'b1;
                grant_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/edge_event_scheduler.sv
// Collects per-channel rising/falling edge pulses into pending bits and
// presents them one at a time on a valid/ready port in round-robin order.
module edge_event_scheduler
    import edge_event_scheduler_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] posedge_in,
    input  logic [NCH-1:0] negedge_in,
    output logic           event_valid,
    input  logic           event_ready,
    output logic [CHW-1:0] event_chan,
    output logic           event_rising,
    output logic [NCH-1:0] overflow,
    input  logic           overflow_clr,
    output logic           busy
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [NCH-1:0] r_pend_rise, r_pend_fall, r_order, r_overflow;
    logic [CHW-1:0] r_last_grant, r_chan;
    logic           r_rising;

    logic [NCH-1:0] w_req, w_clr_rise, w_clr_fall, w_kept_rise, w_kept_fall;
    logic [NCH-1:0] w_order_nxt, w_ovf_set;
    logic           w_gv, w_load, w_sel_rise;
    logic [CHW-1:0] w_gidx;

    assign w_req = r_pend_rise | r_pend_fall;

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant_valid(w_gv),
        .grant_idx  (w_gidx)
    );

    // r_order[i] = 1 means the rise edge arrived first (or tied).
    assign w_sel_rise = (r_pend_rise[w_gidx] && r_pend_fall[w_gidx]) ?
                        r_order[w_gidx] : r_pend_rise[w_gidx];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gv) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (event_ready) begin
                    if (w_gv) w_load = 1'b1;
                    else      w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_clr_rise  = (w_load &&  w_sel_rise) ? (NCH'(1) << w_gidx) : '0;
    assign w_clr_fall  = (w_load && !w_sel_rise) ? (NCH'(1) << w_gidx) : '0;
    assign w_kept_rise = r_pend_rise & ~w_clr_rise;
    assign w_kept_fall = r_pend_fall & ~w_clr_fall;
    assign w_ovf_set   = (w_kept_rise & posedge_in) | (w_kept_fall & negedge_in);

    // A surviving bit is older than a newly arriving one; simultaneous arrivals favour rise.
    always_comb begin
        w_order_nxt = r_order;
        for (int i = 0; i < NCH; i++) begin
            if (!(w_kept_rise[i] && w_kept_fall[i]))
                w_order_nxt[i] = w_kept_rise[i] || !w_kept_fall[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pend_rise  <= '0;
            r_pend_fall  <= '0;
            r_order      <= '0;
            r_overflow   <= '0;
            r_chan       <= '0;
            r_rising     <= 1'b0;
            r_last_grant <= CHW'(NCH - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_pend_rise <= w_kept_rise | posedge_in;
            r_pend_fall <= w_kept_fall | negedge_in;
            r_order     <= w_order_nxt;
            r_overflow  <= (overflow_clr ? '0 : r_overflow) | w_ovf_set;
            if (w_load) begin
                r_chan       <= w_gidx;
                r_rising     <= w_sel_rise;
                r_last_grant <= w_gidx;
            end
        end
    end

    assign event_valid  = (r_state == ST_PRESENT);
    assign event_chan   = r_chan;
    assign event_rising = r_rising;
    assign overflow     = r_overflow;
    assign busy         = event_valid | (|w_req);

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler: a vector table for the basic
// flows plus hand-written multi-cycle sequences for the corner cases.
module tb_edge_event_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] posedge_in, negedge_in, overflow;
    logic       event_valid, event_ready, event_rising, overflow_clr, busy;
    logic [1:0] event_chan;

    int n_cmp = 0;
    int n_err = 0;

    edge_event_scheduler #(.NCH(4), .CHW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .posedge_in  (posedge_in),
        .negedge_in  (negedge_in),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_chan  (event_chan),
        .event_rising(event_rising),
        .overflow    (overflow),
        .overflow_clr(overflow_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pos;
        logic [3:0] neg;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [1:0] ec;
        logic       er;
        logic [3:0] eo;
        logic       eb;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] pos, input logic [3:0] neg, input logic rdy, input logic clr);
        posedge_in   = pos;
        negedge_in   = neg;
        event_ready  = rdy;
        overflow_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ev(input string name, input logic v, input logic [1:0] c, input logic r);
        chk({name, "_valid"}, 32'(event_valid), 32'(v));
        if (v) begin
            chk({name, "_chan"}, 32'(event_chan), 32'(c));
            chk({name, "_rising"}, 32'(event_rising), 32'(r));
        end
    endtask

    initial begin
        // pos, neg, rdy, clr | valid, chan, rising, overflow, busy
        vt[0]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
        vt[1]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000, 1'b1};
        vt[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b1};
        vt[3]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b1};
        vt[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1};
        vt[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
        vt[6]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
        vt[7]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b1};
        vt[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
        vt[9]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
        vt[10] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1};
        vt[11] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b1};
        vt[12] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};

        reset = 1'b1;
        posedge_in = '0; negedge_in = '0; event_ready = 1'b0; overflow_clr = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_valid", 32'(event_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_chan", 32'(event_chan), 32'd0);
        chk("rst_rising", 32'(event_rising), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step(vt[i].pos, vt[i].neg, vt[i].rdy, vt[i].clr);
            chk_ev($sformatf("vec%0d", i), vt[i].ev, vt[i].ec, vt[i].er);
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vt[i].eo));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].eb));
        end

        // Backpressure: chan1 rise held while chan3 fall waits behind it.
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk_ev("bp_load", 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, (i == 0) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
            chk_ev($sformatf("bp_hold%0d", i), 1'b1, 2'd1, 1'b1);
        end
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("bp_next", 1'b1, 2'd3, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("bp_idle", 1'b0, 2'd0, 1'b0);
        chk("bp_busy", 32'(busy), 32'd0);

        // Ordering and overflow on chan0 while chan1 is stalled at the output.
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("ord_no_ovf", 32'(overflow), 32'd0);
        step(4'b0000, 4'b0001, 1'b0, 1'b0);
        chk("ord_ovf", 32'(overflow), 32'b0001);
        chk_ev("ord_stall", 1'b1, 2'd1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("ord_first", 1'b1, 2'd0, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("ord_second", 1'b1, 2'd0, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("ord_done", 1'b0, 2'd0, 1'b0);
        chk("ord_busy", 32'(busy), 32'd0);
        chk("ord_sticky", 32'(overflow), 32'b0001);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("ord_clr", 32'(overflow), 32'd0);

        // Clear coincident with a fresh overflow: the new overflow wins.
        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        step(4'b1000, 4'b0000, 1'b0, 1'b1);
        chk("clr_race_ovf", 32'(overflow), 32'b1000);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        chk("clr_race_clr", 32'(overflow), 32'd0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("clr_race_ev", 1'b1, 2'd3, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("clr_race_idle", 1'b0, 2'd0, 1'b0);

        // Same-edge reload: new chan2 rise arrives on the transfer edge.
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk_ev("rel_first", 1'b1, 2'd2, 1'b1);
        step(4'b0100, 4'b0000, 1'b1, 1'b0);
        chk("rel_ovf", 32'(overflow), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("rel_second", 1'b1, 2'd2, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk_ev("rel_idle", 1'b0, 2'd0, 1'b0);

        // Reset asserted between edges with events pending and presented.
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0110, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b1000, 1'b0, 1'b0);
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        chk_ev("mid_pre", 1'b1, 2'd0, 1'b1);
        chk("mid_pre_ovf", 32'(overflow), 32'b0010);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(event_valid), 32'd0);
        chk("mid_rst_chan", 32'(event_chan), 32'd0);
        chk("mid_rst_rising", 32'(event_rising), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        posedge_in = 4'b1111;
        @(posedge clk);
        #2;
        posedge_in = '0;
        reset = 1'b0;
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        step(4'b1101, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        chk_ev("post_rst_first", 1'b1, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_event_scheduler.md
EDGE_EVENT_SCHEDULER -- requirements
Module: edge_event_scheduler

Interface
REQ-001 Parameter NCH, 4, number of input conditioner channels served (power of two, 2..8).
REQ-002 Parameter CHW, log2(NCH), width of channel index.
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port posedge_in  input  NCH  one-cycle positiveedge pulses, one bit per conditioner channel.
REQ-006 Port negedge_in  input  NCH  one-cycle negativeedge pulses, one bit per conditioner channel.
REQ-007 Port event_valid  output  1  event payload present.
REQ-008 Port event_ready  input  1  consumer accepts event this cycle.
REQ-009 Port event_chan  output  CHW  channel index of presented event.
REQ-010 Port event_rising  output  1  1 = rising edge event, 0 = falling edge event.
REQ-011 Port overflow  output  NCH  sticky per-channel lost-event flag.
REQ-012 Port overflow_clr  input  1  synchronous clear of all overflow bits.
REQ-013 Port busy  output  1  high when any event is pending or event_valid is high.

Function
REQ-014 Per channel i, pend_rise[i] / pend_fall[i] SHALL set on the edge sampling posedge_in[i] / negedge_in[i] high.
REQ-015 Per channel, an order bit SHALL record which pending bit was set first; if both set on the same edge, rise is treated as first.
REQ-016 Two states: IDLE (event_valid=0) and PRESENT (event_valid=1).
REQ-017 IDLE -> PRESENT on any edge where some pending bit is set; output registers SHALL load the winner and its pending bit SHALL clear on that edge.
REQ-018 Latency: pulse sampled at edge k, scheduler idle with nothing pending -> event_valid high after edge k+1.
REQ-019 Transfer occurs on an edge with event_valid && event_ready.
REQ-020 On transfer, if any pending bit is set, the next winner SHALL load on the same edge (valid stays high, back-to-back); otherwise -> IDLE.
REQ-021 While event_valid && !event_ready, event_chan and event_rising SHALL hold stable.
REQ-022 Channel selection SHALL be round-robin: search from last_grant+1 upward, wrapping at NCH-1 to 0; last_grant updates on every load.
REQ-023 Within a selected channel with both bits pending, the first-arrived edge (per order bit) SHALL be emitted; the other remains pending.
REQ-024 A pulse for a pending bit that is set and not being cleared on that edge SHALL set overflow[i]; the event is dropped (no double count).
REQ-025 A pulse for a bit being cleared by a load on the same edge SHALL re-set that bit; no overflow.
REQ-026 overflow_clr SHALL clear all overflow bits; a new overflow condition on the same edge wins (bit set).
REQ-027 busy = event_valid OR any pending bit, combinational from registers.

Reset
REQ-028 reset high SHALL immediately clear all pending bits, order bits, overflow, event_valid, event_chan=0, event_rising=0, state=IDLE, last_grant=NCH-1 (channel 0 first priority).
REQ-029 Reset asserted mid-handshake SHALL discard the presented event; no transfer is counted for that cycle.
REQ-030 Pulses coincident with reset deassertion edge SHALL be ignored.

Structure
REQ-031 NCH, CHW and the state encodings SHALL live in the shared lab constants package/header.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req[NCH], last_grant; outputs grant_valid, grant_idx), purely combinational.
REQ-033 Pending/overflow storage, order bits, FSM and output registers SHALL reside in edge_event_scheduler.

Verification
REQ-034 Single event: posedge_in=4'b0100 one cycle, event_ready=1 -> event_valid after 2nd edge, event_chan=2, event_rising=1, then IDLE, busy=0.
REQ-035 Round-robin: negedge_in=4'b1111 one cycle, ready=1 -> events chan 0,1,2,3 back-to-back, all event_rising=0, valid high 4 consecutive cycles.
REQ-036 Backpressure: chan1 rise presented, ready=0 for 5 cycles while chan3 fall arrives -> chan1/rise held stable 5 cycles, then chan3/fall after ready=1.
REQ-037 Ordering/overflow: ready=0; chan0 fall, then chan0 rise, then chan0 fall again -> overflow=4'b0001; after ready=1 events fall then rise only; overflow_clr -> overflow=0.
REQ-038 Same-edge reload: chan2 rise presented, transfer edge coincides with new posedge_in[2] -> no overflow, second chan2 rise event follows.
REQ-039 Reset mid-operation: 3 pending + valid high, assert reset between edges -> all outputs 0 immediately; after release, chan0 wins first.
